// File: rtl/prio_encoder_q.sv
// Registered priority encoder with sticky request capture, valid/ready output
// and run-time selectable fixed-priority or round-robin arbitration.
module prio_encoder_q #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iClear,
  input  logic         iRrEn,
  input  logic [N-1:0] iReq,
  input  logic         iReady,
  output logic         oValid,
  output logic [W-1:0] oData,
  output logic [N-1:0] oPend,
  output logic [W:0]   oCount
);

  logic [N-1:0] pend_q, pend_d;
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] last_q, last_d;

  logic [N-1:0] lo_mask;
  logic [N-1:0] lo_hit;
  logic [N-1:0] clr_sel;
  logic [W-1:0] sel;
  logic         load;
  logic         issue;
  logic [W:0]   cnt;

  function automatic logic [W-1:0] highest(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // Round-robin scans last-1 down to 0 first, then wraps from N-1 down to last:
  // that is the highest pending bit below last, else the highest pending bit.
  always_comb begin
    lo_mask = '0;
    for (int i = 0; i < N; i++) begin
      lo_mask[i] = (W'(i) < last_q);
    end
    lo_hit  = pend_q & lo_mask;
    sel     = (iRrEn && (|lo_hit)) ? highest(lo_hit) : highest(pend_q);
    load    = !valid_q || iReady;
    issue   = load && (|pend_q);
    clr_sel = issue ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
  end

  always_comb begin
    pend_d  = (pend_q & ~clr_sel) | iReq;
    valid_d = load ? issue : valid_q;
    data_d  = issue ? sel : data_q;
    last_d  = issue ? sel : last_q;
    if (iClear) begin
      pend_d  = '0;
      valid_d = 1'b0;
      data_d  = data_q;
      last_d  = '0;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + (W+1)'(pend_q[i]);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign oValid = valid_q;
  assign oData  = data_q;
  assign oPend  = pend_q;
  assign oCount = cnt;

endmodule
